// File: rtl/meta_alu_pipe.sv
// rtl/meta_alu_pipe.sv - metadata ALU: opcode-driven field rewrite carried through a LATENCY-deep pipeline
// Optional statistics counters compiled in with `define META_ALU_STATS_EN.
module meta_alu_pipe #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int META_LEN   = 256,
  parameter int LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [META_LEN-1:0]   comp_meta_data_in,
  input  logic                  comp_meta_data_valid_in,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid_in,
  output logic [META_LEN-1:0]   comp_meta_data_out,
  output logic                  comp_meta_data_valid_out,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_discard_cnt,
  output logic [31:0]           stat_mismatch_cnt
);

  logic [3:0]          w_opcode;
  logic [7:0]          w_dst_port;
  logic                w_discard;
  logic [5:0]          w_next_tid;
  logic [META_LEN-1:0] w_result;

  assign w_opcode   = action_in[24:21];
  assign w_dst_port = action_in[20:13];
  assign w_discard  = action_in[12];
  assign w_next_tid = action_in[10:5];

  // Bits not listed in the decode (and the bookkeeping-only stage index) are intentionally unused.
  logic [31:0] w_unused_stage;
  logic        w_unused;
  assign w_unused_stage = STAGE_ID;
  assign w_unused       = ^{action_in, comp_meta_data_valid_in, w_unused_stage};

  always_comb begin
    w_result = comp_meta_data_in;
    case (w_opcode)
      4'b1100: begin
        w_result[31:24]             = w_dst_port;
        w_result[META_LEN-1 -: 6]   = w_next_tid;
      end
      4'b1101: begin
        w_result[128]               = w_discard;
        w_result[META_LEN-1 -: 6]   = w_next_tid;
      end
      4'b1110: begin
        w_result[31:24]             = w_dst_port;
        w_result[128]               = w_discard;
        w_result[META_LEN-1 -: 6]   = w_next_tid;
      end
      4'b1111: w_result[META_LEN-1 -: 6] = w_next_tid;
      default: ;
    endcase
  end

  logic [LATENCY-1:0]  r_v;
  logic [META_LEN-1:0] r_d [LATENCY];
  logic [LATENCY-1:0]  w_v_in;
  logic [META_LEN-1:0] w_d_in [LATENCY];

  always_comb begin
    w_v_in[0] = action_valid_in;
    w_d_in[0] = w_result;
    for (int i = 1; i < LATENCY; i++) begin
      w_v_in[i] = r_v[i-1];
      w_d_in[i] = r_d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_v <= '0;
    else        r_v <= w_v_in;
  end

  // Data moves only with a valid token, so the last stage holds the last emitted result across bubbles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      if (w_v_in[i]) r_d[i] <= w_d_in[i];
    end
    if (!rst_n) r_d[LATENCY-1] <= '0;
  end

  assign comp_meta_data_out       = r_d[LATENCY-1];
  assign comp_meta_data_valid_out = r_v[LATENCY-1];

`ifdef META_ALU_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_discard_cnt;
  logic [31:0] r_mismatch_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt_cnt      <= '0;
      r_discard_cnt  <= '0;
      r_mismatch_cnt <= '0;
    end else begin
      if (comp_meta_data_valid_out && r_pkt_cnt != 32'hFFFF_FFFF)
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (comp_meta_data_valid_out && comp_meta_data_out[128] && r_discard_cnt != 32'hFFFF_FFFF)
        r_discard_cnt <= r_discard_cnt + 32'd1;
      if (action_valid_in && !comp_meta_data_valid_in && r_mismatch_cnt != 32'hFFFF_FFFF)
        r_mismatch_cnt <= r_mismatch_cnt + 32'd1;
    end
  end

  assign stat_pkt_cnt      = r_pkt_cnt;
  assign stat_discard_cnt  = r_discard_cnt;
  assign stat_mismatch_cnt = r_mismatch_cnt;
`else
  assign stat_pkt_cnt      = 32'd0;
  assign stat_discard_cnt  = 32'd0;
  assign stat_mismatch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_meta_alu_pipe.sv
// tb/tb_meta_alu_pipe.sv - scoreboard bench for meta_alu_pipe, LATENCY=5 and LATENCY=1 side by side
module tb_meta_alu_pipe;
  typedef struct {
    logic [255:0] d;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] meta_in = '0;
  logic         mv_in = 1'b0;
  logic [24:0]  act = '0;
  logic         av = 1'b0;

  logic [255:0] out5, out1;
  logic         v5, v1;
  logic [31:0]  pkt5, disc5, mis5, pkt1, disc1, mis1;

  exp_t         q5[$];
  exp_t         q1[$];
  logic [255:0] last5 = '0;
  logic [255:0] last1 = '0;
  int cyc = 0, total = 0, bad = 0;
  int exp_pkt = 0, exp_disc = 0, exp_mis = 0;

  meta_alu_pipe #(.STAGE_ID(0), .ACTION_LEN(25), .META_LEN(256), .LATENCY(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .comp_meta_data_in(meta_in), .comp_meta_data_valid_in(mv_in),
    .action_in(act), .action_valid_in(av),
    .comp_meta_data_out(out5), .comp_meta_data_valid_out(v5),
    .stat_pkt_cnt(pkt5), .stat_discard_cnt(disc5), .stat_mismatch_cnt(mis5)
  );

  meta_alu_pipe #(.STAGE_ID(1), .ACTION_LEN(25), .META_LEN(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .comp_meta_data_in(meta_in), .comp_meta_data_valid_in(mv_in),
    .action_in(act), .action_valid_in(av),
    .comp_meta_data_out(out1), .comp_meta_data_valid_out(v1),
    .stat_pkt_cnt(pkt1), .stat_discard_cnt(disc1), .stat_mismatch_cnt(mis1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] mk(logic [3:0] op, logic [7:0] dst, logic disc, logic [5:0] tid);
    return {op, dst, disc, 1'b0, tid, 5'b0};
  endfunction

  // Reference: which fields an opcode writes, then overwrite just those fields.
  function automatic logic [255:0] model(logic [255:0] m, logic [24:0] a);
    logic [255:0] r;
    logic [3:0]   op;
    r  = m;
    op = a[24:21];
    if (op == 4'd12 || op == 4'd14) r[31:24] = a[20:13];
    if (op == 4'd13 || op == 4'd14) r[128] = a[12];
    if (op >= 4'd12) r[255:250] = a[10:5];
    return r;
  endfunction

  task automatic chk(string name, logic [255:0] got, logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (v5) begin
        if (q5.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid5 got=%h want=no_output at cyc %0d", out5, cyc);
        end else begin
          e = q5.pop_front();
          chk("data5", out5, e.d);
          chk("due5", 256'(cyc), 256'(e.due));
          last5 = e.d;
        end
      end else begin
        chk("hold5", out5, last5);
        if (q5.size() > 0 && q5[0].due < cyc) begin
          total++; bad++;
          $display("FAIL late5 got=no_valid want=valid at cyc %0d", q5[0].due);
          void'(q5.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (v1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid1 got=%h want=no_output at cyc %0d", out1, cyc);
        end else begin
          e = q1.pop_front();
          chk("data1", out1, e.d);
          chk("due1", 256'(cyc), 256'(e.due));
          last1 = e.d;
        end
      end else begin
        chk("hold1", out1, last1);
        if (q1.size() > 0 && q1[0].due < cyc) begin
          total++; bad++;
          $display("FAIL late1 got=no_valid want=valid at cyc %0d", q1[0].due);
          void'(q1.pop_front());
        end
      end
    end
  end

  task automatic drive(logic [255:0] m, logic [24:0] a, logic mv, logic v);
    logic [255:0] r;
    meta_in = m; act = a; mv_in = mv; av = v;
    if (v && rst_n) begin
      r = model(m, a);
      q5.push_back('{r, cyc + 5});
      q1.push_back('{r, cyc + 1});
      exp_pkt++;
      if (r[128]) exp_disc++;
      if (!mv) exp_mis++;
    end
    @(posedge clk); #1;
    av = 1'b0;
  endtask

  task automatic clear_model();
    q5.delete(); q1.delete();
    last5 = '0; last1 = '0;
    exp_pkt = 0; exp_disc = 0; exp_mis = 0;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0; av = 1'b0;
    clear_model();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q5.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (q5.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", q5.size(), q1.size());
    end
  endtask

  task automatic chk_stats(string tag);
`ifdef META_ALU_STATS_EN
    chk({tag, "_pkt5"}, 256'(pkt5), 256'(exp_pkt));
    chk({tag, "_disc5"}, 256'(disc5), 256'(exp_disc));
    chk({tag, "_mis5"}, 256'(mis5), 256'(exp_mis));
    chk({tag, "_pkt1"}, 256'(pkt1), 256'(exp_pkt));
    chk({tag, "_disc1"}, 256'(disc1), 256'(exp_disc));
    chk({tag, "_mis1"}, 256'(mis1), 256'(exp_mis));
`else
    chk({tag, "_pkt5"}, 256'(pkt5), 256'(0));
    chk({tag, "_disc5"}, 256'(disc5), 256'(0));
    chk({tag, "_mis5"}, 256'(mis5), 256'(0));
    chk({tag, "_mis1"}, 256'(mis1), 256'(0));
`endif
  endtask

  initial begin
    logic [255:0] ones;
    logic [255:0] rm;
    logic [24:0]  ra;
    ones = '1;

    #1;
    do_reset(3);
    chk("rst_v5", 256'(v5), 256'(0));
    chk("rst_out5", out5, 256'(0));
    chk("rst_v1", 256'(v1), 256'(0));
    chk("rst_out1", out1, 256'(0));
    chk_stats("rst");

    // Opcode 1100 on zero metadata: only dst_port and next_table_id change.
    drive('0, mk(4'b1100, 8'h04, 1'b0, 6'h03), 1'b1, 1'b1);
    drain();
    chk("directed_1100", out5, {6'h03, 218'd0, 8'h04, 24'd0});

    // Back-to-back opcode sweep on all-ones metadata.
    drive(ones, mk(4'b1101, 8'h12, 1'b0, 6'h05), 1'b1, 1'b1);
    drive(ones, mk(4'b1110, 8'h34, 1'b0, 6'h0A), 1'b1, 1'b1);
    drive(ones, mk(4'b1111, 8'h56, 1'b0, 6'h11), 1'b1, 1'b1);
    drive(ones, mk(4'b0000, 8'h78, 1'b0, 6'h00), 1'b1, 1'b1);
    drive(ones, mk(4'b1100, 8'h9A, 1'b0, 6'h22), 1'b1, 1'b1);
    drain();
    chk_stats("sweep");

    do_reset(1);
    drive('0, mk(4'b1101, 8'h00, 1'b1, 6'h01), 1'b1, 1'b1);
    drain();
    chk("discard_bit", 256'(out5[128]), 256'(1));
    chk_stats("discard");

    // Reset after the second accept; the third accept coincides with reset and must be ignored.
    drive(ones, mk(4'b1100, 8'h01, 1'b0, 6'h01), 1'b1, 1'b1);
    drive(ones, mk(4'b1110, 8'h02, 1'b1, 6'h02), 1'b1, 1'b1);
    rst_n = 1'b0;
    clear_model();
    meta_in = ones; act = mk(4'b1111, 8'h03, 1'b0, 6'h03); av = 1'b1; mv_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; av = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_out5", out5, 256'(0));
    chk("midrst_out1", out1, 256'(0));
    chk_stats("midrst");

    drive(ones, mk(4'b1111, 8'h00, 1'b0, 6'h2A), 1'b0, 1'b1);
    drain();
    chk_stats("mismatch");

    // Continuous stream of ten accepts.
    for (int i = 0; i < 10; i++) begin
      rm = {8{$urandom()}};
      drive(rm, mk(4'(12 + i % 4), 8'(i * 17), 1'(i), 6'(i * 5)), 1'b1, 1'b1);
    end
    drain();
    chk_stats("stream");

    for (int i = 0; i < 200; i++) begin
      for (int w = 0; w < 8; w++) rm[w*32 +: 32] = $urandom();
      ra = 25'($urandom());
      ra[24:21] = 4'($urandom_range(10, 15));
      drive(rm, ra, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    drain();
    chk_stats("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
